// File: rtl/spi_regfile_peripheral_pkg.sv
// Shared types and helpers for the SPI register-file target.
package spi_regfile_peripheral_pkg;

    // Frame layout: one R/W bit, then the address field, then the data field.
    function automatic int frame_width(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

    // The bit counter must hold FRAME_W+1 so that long frames stay distinguishable.
    function automatic int count_width(input int frame_w);
        return $clog2(frame_w + 2);
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HDR    = 2'd1,
        ST_DATA   = 2'd2,
        ST_COMMIT = 2'd3
    } spi_state_t;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

endpackage

// File: rtl/spi_regfile_peripheral_if.sv
// SPI pin bundle between a controller and the register-file target.
interface spi_regfile_peripheral_if;
    logic SCLK;
    logic COPI;
    logic nCS;
    logic CIPO;
    logic cipo_oe;

    modport master (output SCLK, output COPI, output nCS, input CIPO, input cipo_oe);
    modport slave  (input SCLK, input COPI, input nCS, output CIPO, output cipo_oe);
endinterface

// File: rtl/spi_regfile_peripheral_sync_edge.sv
// Multi-flop synchroniser with single-cycle rise/fall pulses on the synchronised level.
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain_reg;
    logic              prev_reg;

    // Shift the asynchronous input through the chain and keep one delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_reg <= {STAGES{RESET_VAL}};
            prev_reg  <= RESET_VAL;
        end else begin
            chain_reg <= {chain_reg[STAGES-2:0], din};
            prev_reg  <= chain_reg[STAGES-1];
        end
    end

    assign level = chain_reg[STAGES-1];
    assign rise  = level & ~prev_reg;
    assign fall  = ~level & prev_reg;

endmodule

// File: rtl/spi_regfile_peripheral.sv
// SPI Mode-0 register-file target: oversampled pins, framed writes/reads, error flags.
module spi_regfile_peripheral
    import spi_regfile_peripheral_pkg::*;
#(
    parameter int NUM_REGS    = 5,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    spi_regfile_peripheral_if.slave      spi,
    input  logic                         err_clr,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
    output logic                         wr_strobe,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         err_addr,
    output logic                         err_len
);

    localparam int FRAME_W = frame_width(ADDR_W, DATA_W);
    localparam int CNT_W   = count_width(FRAME_W);
    localparam int HDR_W   = 1 + ADDR_W;

    // Index 0 = SCLK, 1 = COPI, 2 = nCS (nCS idles high, so its chain resets high).
    logic [2:0] pin_raw, pin_lvl, pin_rise, pin_fall;
    assign pin_raw = {spi.nCS, spi.COPI, spi.SCLK};

    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
        spi_sync_edge #(
            .STAGES    (SYNC_STAGES),
            .RESET_VAL ((gi == 2) ? 1'b1 : 1'b0)
        ) u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (pin_raw[gi]),
            .level (pin_lvl[gi]),
            .rise  (pin_rise[gi]),
            .fall  (pin_fall[gi])
        );
    end

    logic sclk_rise, sclk_fall, copi_lvl, ncs_lvl, ncs_rise, ncs_fall;
    assign sclk_rise = pin_rise[0];
    assign sclk_fall = pin_fall[0];
    assign copi_lvl  = pin_lvl[1];
    assign ncs_lvl   = pin_lvl[2];
    assign ncs_rise  = pin_rise[2];
    assign ncs_fall  = pin_fall[2];

    logic unused_pins;
    assign unused_pins = ^{pin_lvl[0], pin_rise[1], pin_fall[1]};

    spi_state_t          state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [FRAME_W-1:0]  shift_in_reg, shift_in_next;
    logic [DATA_W-1:0]   shift_out_reg;
    logic                cipo_oe_reg;
    logic [DATA_W-1:0]   regs_reg [NUM_REGS];
    logic                wr_strobe_reg;
    logic [ADDR_W-1:0]   wr_addr_reg;
    logic                err_addr_reg;
    logic                err_len_reg;

    // A frame bit is taken only while selected and never in the same cycle nCS releases.
    logic in_frame, bit_rise;
    assign in_frame = (state_reg == ST_HDR) || (state_reg == ST_DATA);
    assign bit_rise = in_frame && sclk_rise && !ncs_rise && !ncs_lvl;

    assign cnt_next      = (cnt_reg == CNT_W'(FRAME_W + 1)) ? cnt_reg : cnt_reg + 1'b1;
    assign shift_in_next = {shift_in_reg[FRAME_W-2:0], copi_lvl};

    // Header fields as they stand once the last header bit is shifted in.
    logic              hdr_rw;
    logic [ADDR_W-1:0] hdr_addr;
    assign hdr_rw   = shift_in_next[ADDR_W];
    assign hdr_addr = shift_in_next[ADDR_W-1:0];

    // Fields of a completed frame, examined during COMMIT.
    logic              cmt_rw, cmt_full, cmt_in_range, cmt_wr;
    logic [ADDR_W-1:0] cmt_addr;
    logic [DATA_W-1:0] cmt_data;
    assign cmt_rw       = shift_in_reg[FRAME_W-1];
    assign cmt_addr     = shift_in_reg[DATA_W +: ADDR_W];
    assign cmt_data     = shift_in_reg[DATA_W-1:0];
    assign cmt_full     = (cnt_reg == CNT_W'(FRAME_W));
    assign cmt_in_range = ({1'b0, cmt_addr} < (ADDR_W+1)'(NUM_REGS));
    assign cmt_wr       = (state_reg == ST_COMMIT) && cmt_full && cmt_in_range && (cmt_rw == RW_WRITE);

    // Read-data lookup; out-of-range addresses match no entry and return zero.
    logic [DATA_W-1:0] rd_word;
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (hdr_addr == ADDR_W'(i)) rd_word = regs_reg[i];
        end
    end

    // Next-state logic: nCS release always ends the frame, even mid-header.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (ncs_fall) state_next = ST_HDR;
            ST_HDR: begin
                if (ncs_rise)                                        state_next = ST_COMMIT;
                else if (bit_rise && cnt_reg == CNT_W'(HDR_W - 1))   state_next = ST_DATA;
            end
            ST_DATA:   if (ncs_rise) state_next = ST_COMMIT;
            ST_COMMIT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    // Frame datapath: bit capture, read shift-out, commit outcome and error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg       <= '0;
            shift_in_reg  <= '0;
            shift_out_reg <= '0;
            cipo_oe_reg   <= 1'b0;
            wr_strobe_reg <= 1'b0;
            wr_addr_reg   <= '0;
            err_addr_reg  <= 1'b0;
            err_len_reg   <= 1'b0;
        end else begin
            wr_strobe_reg <= 1'b0;
            err_len_reg   <= 1'b0;
            if (err_clr) err_addr_reg <= 1'b0;

            if (state_reg == ST_IDLE && ncs_fall) begin
                cnt_reg      <= '0;
                shift_in_reg <= '0;
            end

            if (bit_rise) begin
                cnt_reg      <= cnt_next;
                shift_in_reg <= shift_in_next;
            end

            if (state_reg == ST_HDR && state_next == ST_DATA && hdr_rw == RW_READ) begin
                shift_out_reg <= rd_word;
                cipo_oe_reg   <= 1'b1;
            end

            // The fall right after the last header bit must not shift: the MSB is
            // only just loaded and the controller samples it on the next rise.
            if (state_reg == ST_DATA && cipo_oe_reg && sclk_fall && !ncs_rise &&
                cnt_reg > CNT_W'(HDR_W)) begin
                shift_out_reg <= {shift_out_reg[DATA_W-2:0], 1'b0};
            end

            if (state_next == ST_COMMIT && state_reg != ST_COMMIT) begin
                shift_out_reg <= '0;
                cipo_oe_reg   <= 1'b0;
            end

            if (state_reg == ST_COMMIT) begin
                if (!cmt_full) begin
                    err_len_reg <= 1'b1;
                end else if (!cmt_in_range) begin
                    err_addr_reg <= 1'b1;
                end else if (cmt_rw == RW_WRITE) begin
                    wr_strobe_reg <= 1'b1;
                    wr_addr_reg   <= cmt_addr;
                end
            end
        end
    end

    // One flop group per register, updated on the same edge that raises wr_strobe.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                                  regs_reg[gi] <= '0;
            else if (cmt_wr && cmt_addr == ADDR_W'(gi))  regs_reg[gi] <= cmt_data;
        end
        assign regs_flat[gi*DATA_W +: DATA_W] = regs_reg[gi];
    end

    assign spi.CIPO    = shift_out_reg[DATA_W-1];
    assign spi.cipo_oe = cipo_oe_reg;
    assign wr_strobe   = wr_strobe_reg;
    assign wr_addr     = wr_addr_reg;
    assign err_addr    = err_addr_reg;
    assign err_len     = err_len_reg;

endmodule
